// File: rtl/cram_read_arbiter.sv
// Two-port round-robin arbiter for the CRAM AXI4 read channel: single-beat
// AR requests are funnelled to one slave port and R beats are steered back by RID.
module cram_read_arbiter #(
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              nrst,

  input  logic [ADDR_W-1:0] p0_araddr,
  input  logic              p0_arvalid,
  output logic              p0_arready,
  output logic [31:0]       p0_rdata,
  output logic [1:0]        p0_rresp,
  output logic              p0_rvalid,
  input  logic              p0_rready,

  input  logic [ADDR_W-1:0] p1_araddr,
  input  logic              p1_arvalid,
  output logic              p1_arready,
  output logic [31:0]       p1_rdata,
  output logic [1:0]        p1_rresp,
  output logic              p1_rvalid,
  input  logic              p1_rready,

  output logic [3:0]        s_cram_arid,
  output logic [ADDR_W-1:0] s_cram_araddr,
  output logic [7:0]        s_cram_arlen,
  output logic [2:0]        s_cram_arsize,
  output logic [1:0]        s_cram_arburst,
  output logic              s_cram_arvalid,
  input  logic              s_cram_arready,
  input  logic [3:0]        s_cram_rid,
  input  logic [31:0]       s_cram_rdata,
  input  logic [1:0]        s_cram_rresp,
  input  logic              s_cram_rlast,
  input  logic              s_cram_rvalid,
  output logic              s_cram_rready,
  output logic              o_rid_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

  state_t     state;
  logic [3:0] cnt [2];
  logic       rr_last;

  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] ar_hs;
  logic [1:0] r_hs;
  logic       rid_is0;
  logic       rid_is1;
  logic       unused_rlast;

  assign unused_rlast   = s_cram_rlast;
  assign s_cram_arlen   = 8'h00;
  assign s_cram_arsize  = 3'h2;
  assign s_cram_arburst = 2'h1;

  // Grant decision is combinational so arready lands in the request cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    elig  = 2'b00;
    grant = 2'b00;
    elig[0] = p0_arvalid && (cnt[0] < MAX_CNT);
    elig[1] = p1_arvalid && (cnt[1] < MAX_CNT);
    if (state == IDLE && nrst) begin
      if (&elig) begin
        grant = rr_last ? 2'b01 : 2'b10;
      end else begin
        grant = elig;
      end
    end
  end

  assign p0_arready = grant[0];
  assign p1_arready = grant[1];

  assign ar_hs[0] = s_cram_arvalid && s_cram_arready && !s_cram_arid[0];
  assign ar_hs[1] = s_cram_arvalid && s_cram_arready &&  s_cram_arid[0];

  // R steering: known IDs pass straight through, anything else is swallowed.
  assign rid_is0       = (s_cram_rid == 4'd0);
  assign rid_is1       = (s_cram_rid == 4'd1);
  assign p0_rvalid     = s_cram_rvalid && rid_is0;
  assign p1_rvalid     = s_cram_rvalid && rid_is1;
  assign s_cram_rready = rid_is0 ? p0_rready : (rid_is1 ? p1_rready : 1'b1);
  assign p0_rdata      = s_cram_rdata;
  assign p1_rdata      = s_cram_rdata;
  assign p0_rresp      = s_cram_rresp;
  assign p1_rresp      = s_cram_rresp;
  assign r_hs[0]       = p0_rvalid && p0_rready;
  assign r_hs[1]       = p1_rvalid && p1_rready;

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), so nrst appears
    // only inside this block and never in the sensitivity list.
    if (!nrst) begin
      state          <= IDLE;
      s_cram_arvalid <= 1'b0;
      s_cram_araddr  <= '0;
      s_cram_arid    <= 4'd0;
      rr_last        <= 1'b1;
      cnt[0]         <= 4'd0;
      cnt[1]         <= 4'd0;
      o_rid_err      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in
      // this block sees the pre-edge value regardless of statement order.
      case (state)
        IDLE: begin
          if (|grant) begin
            s_cram_araddr  <= grant[1] ? p1_araddr : p0_araddr;
            s_cram_arid    <= {3'b000, grant[1]};
            rr_last        <= grant[1];
            s_cram_arvalid <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (s_cram_arready) begin
            s_cram_arvalid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Simultaneous accept and return for one port cancel out.
      for (int i = 0; i < 2; i++) begin
        if (ar_hs[i] && !r_hs[i]) begin
          cnt[i] <= cnt[i] + 4'd1;
        end else if (r_hs[i] && !ar_hs[i] && cnt[i] != 4'd0) begin
          cnt[i] <= cnt[i] - 4'd1;
        end
        if (r_hs[i] && cnt[i] == 4'd0) begin
          o_rid_err <= 1'b1;
        end
      end

      if (s_cram_rvalid && !rid_is0 && !rid_is1) begin
        o_rid_err <= 1'b1;
      end
    end
  end

endmodule
